// File: rtl/max_pool_2d_stream.sv
// Streaming KxK max-pool (stride = kernel) over a raster-scanned feature map, all channels in parallel.
// Horizontal maxima are reduced in hmax, vertical partial maxima live in a per-window-column line buffer.
module max_pool_2d_stream #(
    parameter int NBITS      = 32,
    parameter int NFMAPS     = 32,
    parameter int KER_SIZE_X = 2,
    parameter int KER_SIZE_Y = 2,
    parameter int IN_WIDTH   = 32,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBITS*NFMAPS-1:0] in_act,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBITS*NFMAPS-1:0] out_act
);

    localparam int ACTW = NBITS * NFMAPS;
    localparam int NPX  = IN_WIDTH / KER_SIZE_X;
    localparam int KXW  = (KER_SIZE_X > 1) ? $clog2(KER_SIZE_X) : 1;
    localparam int PXW  = (NPX > 1) ? $clog2(NPX) : 1;
    localparam int KYW  = (KER_SIZE_Y > 1) ? $clog2(KER_SIZE_Y) : 1;

    localparam logic [KXW-1:0] KX_LAST = KXW'(KER_SIZE_X - 1);
    localparam logic [PXW-1:0] PX_LAST = PXW'(NPX - 1);
    localparam logic [KYW-1:0] KY_LAST = KYW'(KER_SIZE_Y - 1);

    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    localparam logic [NBITS-1:0] SIGN_BIAS = {SIGNED, {(NBITS-1){1'b0}}};

    // Per-channel max; the incumbent wins ties so output stays bit-exact with the earlier beat.
    function automatic logic [ACTW-1:0] vmax(input logic [ACTW-1:0] inc,
                                             input logic [ACTW-1:0] cand);
        logic [ACTW-1:0]  res;
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] b;
        res = '0;
        for (int c = 0; c < NFMAPS; c++) begin
            a = inc[c*NBITS +: NBITS];
            b = cand[c*NBITS +: NBITS];
            res[c*NBITS +: NBITS] = ((b ^ SIGN_BIAS) > (a ^ SIGN_BIAS)) ? b : a;
        end
        return res;
    endfunction

    logic [KXW-1:0]  kx_q, kx_d;
    logic [PXW-1:0]  px_q, px_d;
    logic [KYW-1:0]  ky_q, ky_d;
    logic [ACTW-1:0] hmax_q, hmax_d;
    logic            out_valid_q, out_valid_d;
    logic [ACTW-1:0] out_act_q, out_act_d;
    logic [ACTW-1:0] linebuf [NPX];

    logic            accept;
    logic            kx_last, px_last, ky_last;
    logic [ACTW-1:0] h_max, lb_rd, v_max, lb_wdata;
    logic            lb_we;

    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign kx_last  = (kx_q == KX_LAST);
    assign px_last  = (px_q == PX_LAST);
    assign ky_last  = (ky_q == KY_LAST);

    assign h_max    = (KER_SIZE_X == 1) ? in_act : vmax(hmax_q, in_act);
    assign lb_rd    = linebuf[px_q];
    assign v_max    = (KER_SIZE_Y == 1) ? h_max : vmax(lb_rd, h_max);
    assign lb_wdata = (ky_q == '0) ? h_max : v_max;
    assign lb_we    = accept & kx_last & ~ky_last;

    always_comb begin
        kx_d        = kx_q;
        px_d        = px_q;
        ky_d        = ky_q;
        hmax_d      = hmax_q;
        out_valid_d = out_valid_q;
        out_act_d   = out_act_q;
        if (flush) begin
            kx_d        = '0;
            px_d        = '0;
            ky_d        = '0;
            hmax_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                hmax_d = (kx_q == '0) ? in_act : vmax(hmax_q, in_act);
                if (kx_last) begin
                    kx_d = '0;
                    if (px_last) begin
                        px_d = '0;
                        ky_d = ky_last ? '0 : ky_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                    // Last row of the window: the pooled beat goes straight to the output register.
                    if (ky_last) begin
                        out_valid_d = 1'b1;
                        out_act_d   = v_max;
                    end
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_q        <= '0;
            px_q        <= '0;
            ky_q        <= '0;
            hmax_q      <= '0;
            out_valid_q <= 1'b0;
            out_act_q   <= '0;
        end else begin
            kx_q        <= kx_d;
            px_q        <= px_d;
            ky_q        <= ky_d;
            hmax_q      <= hmax_d;
            out_valid_q <= out_valid_d;
            out_act_q   <= out_act_d;
        end
    end

    // Line buffer content is never read before it is written for the current window, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[px_q] <= lb_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_act   = out_act_q;

endmodule

// File: tb/tb_max_pool_2d_stream.sv
// Bench for max_pool_2d_stream: signed/unsigned 2x2 pair on shared stimulus plus a 3x2 four-channel instance.
module tb_max_pool_2d_stream;

    typedef logic [31:0] blk8_t [8];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid_ab, out_ready_ab;
    logic [31:0] in_act_ab;
    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [31:0] out_act_a, out_act_b;
    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c;
    logic [63:0] in_act_c, out_act_c;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [63:0] exp_c_q[$];

    always #5 clk = ~clk;

    max_pool_2d_stream #(.NBITS(32), .NFMAPS(1), .KER_SIZE_X(2), .KER_SIZE_Y(2),
                         .IN_WIDTH(4), .SIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_ab), .in_ready(in_ready_a), .in_act(in_act_ab),
        .out_valid(out_valid_a), .out_ready(out_ready_ab), .out_act(out_act_a)
    );

    max_pool_2d_stream #(.NBITS(32), .NFMAPS(1), .KER_SIZE_X(2), .KER_SIZE_Y(2),
                         .IN_WIDTH(4), .SIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_ab), .in_ready(in_ready_b), .in_act(in_act_ab),
        .out_valid(out_valid_b), .out_ready(out_ready_ab), .out_act(out_act_b)
    );

    max_pool_2d_stream #(.NBITS(16), .NFMAPS(4), .KER_SIZE_X(3), .KER_SIZE_Y(2),
                         .IN_WIDTH(6), .SIGNED(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_act(in_act_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_act(out_act_c)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: a beat leaves the DUT on any edge where valid and ready are both high.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic [63:0] ec;
        if (rst_n && out_valid_a && out_ready_ab) begin
            if (exp_a_q.size() == 0) check_val("a_unexpected", 64'(out_valid_a), 64'd0);
            else begin ea = exp_a_q.pop_front(); check_val("a_out", 64'(out_act_a), 64'(ea)); end
        end
        if (rst_n && out_valid_b && out_ready_ab) begin
            if (exp_b_q.size() == 0) check_val("b_unexpected", 64'(out_valid_b), 64'd0);
            else begin eb = exp_b_q.pop_front(); check_val("b_out", 64'(out_act_b), 64'(eb)); end
        end
        if (rst_n && out_valid_c && out_ready_c) begin
            if (exp_c_q.size() == 0) check_val("c_unexpected", 64'(out_valid_c), 64'd0);
            else begin ec = exp_c_q.pop_front(); check_val("c_out", out_act_c, ec); end
        end
    end

    task automatic expect_ab(input logic [31:0] ea, input logic [31:0] eb);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
    endtask

    // Presents one beat and returns on the edge that accepts it.
    task automatic send_ab(input logic [31:0] d);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        #1;
        in_valid_ab = 1'b1;
        in_act_ab   = d;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            guard++;
        end
        if (!acc) check_val("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic stop_ab();
        #1;
        in_valid_ab = 1'b0;
    endtask

    task automatic send8(input blk8_t v);
        for (int i = 0; i < 8; i++) send_ab(v[i]);
    endtask

    function automatic logic [63:0] ramp_c(input int i);
        logic [15:0] c0, c1, c2, c3;
        c0 = 16'(i);
        c1 = 16'(100 - i);
        c2 = 16'(3 * i);
        c3 = 16'(-i);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] v [4], input bit sgn);
        logic [31:0] m;
        m = v[0];
        for (int i = 1; i < 4; i++) begin
            if (sgn ? ($signed(v[i]) > $signed(m)) : (v[i] > m)) m = v[i];
        end
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam int NROWS = 200;
        logic [31:0] rnd [NROWS][4];
        logic [31:0] win [4];
        bit          done;
        int          wait_cyc;

        rst_n = 1'b0; flush = 1'b0;
        in_valid_ab = 1'b0; in_act_ab = '0; out_ready_ab = 1'b1;
        in_valid_c = 1'b0; in_act_c = '0; out_ready_c = 1'b1;

        #2;
        check_val("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        check_val("rst_out_act_a", 64'(out_act_a), 64'd0);
        check_val("rst_out_valid_c", 64'(out_valid_c), 64'd0);
        check_val("rst_out_act_c", out_act_c, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1 check_val("rst_in_ready_a", 64'(in_ready_a), 64'd1);

        // 2x2 pool of {1,-5,3,2},{7,0,-1,4}; unsigned instance sees the negatives as huge values.
        @(posedge clk);
        expect_ab(32'd7, 32'hFFFF_FFFB);
        expect_ab(32'd4, 32'hFFFF_FFFF);
        send_ab(32'd1); send_ab(32'hFFFF_FFFB); send_ab(32'd3); send_ab(32'd2);
        send_ab(32'd7);
        #1 check_val("t1_no_early", 64'(out_valid_a), 64'd0);
        send_ab(32'd0);
        #1 check_val("t1_lat0", 64'(out_valid_a), 64'd1);
        check_val("t1_val0", 64'(out_act_a), 64'd7);
        send_ab(32'hFFFF_FFFF);
        send_ab(32'd4);
        #1 check_val("t1_lat1", 64'(out_valid_a), 64'd1);
        check_val("t1_val1_b", 64'(out_act_b), 64'hFFFF_FFFF);
        stop_ab();

        // Window {0xFFFFFFFF,1,2,3}: signed picks 3, unsigned picks 0xFFFFFFFF.
        @(posedge clk);
        expect_ab(32'd3, 32'hFFFF_FFFF);
        expect_ab(32'd5, 32'd5);
        send8('{32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5, 32'd2, 32'd3, 32'd5, 32'd5});
        stop_ab();

        // Backpressure: result held for five cycles while the next beat waits.
        @(posedge clk);
        #1 out_ready_ab = 1'b0;
        expect_ab(32'd60, 32'd60);
        expect_ab(32'd80, 32'd80);
        send_ab(32'd10); send_ab(32'd20); send_ab(32'd30); send_ab(32'd40);
        send_ab(32'd50); send_ab(32'd60);
        fork
            send_ab(32'd70);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_val("t4_in_ready", 64'(in_ready_a), 64'd0);
                    check_val("t4_hold_valid", 64'(out_valid_a), 64'd1);
                    check_val("t4_hold_act", 64'(out_act_a), 64'd60);
                end
                @(posedge clk);
                #1 out_ready_ab = 1'b1;
            end
        join
        send_ab(32'd80);
        stop_ab();

        // Flush after three beats of a window; the fresh window must not see them.
        @(posedge clk);
        send_ab(32'd100); send_ab(32'd101); send_ab(32'd102);
        #1 flush = 1'b1;
        in_act_ab = 32'd103;
        @(negedge clk);
        check_val("t5_flush_rdy", 64'(in_ready_a), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid_ab = 1'b0;
        check_val("t5_flush_valid", 64'(out_valid_a), 64'd0);
        @(posedge clk);
        expect_ab(32'd9, 32'd9);
        expect_ab(32'd1, 32'd1);
        send8('{32'd9, 32'd8, 32'd1, 32'd1, 32'd7, 32'd6, 32'd1, 32'd1});
        stop_ab();

        // Asynchronous reset between edges drops a pending result and the partial row.
        @(posedge clk);
        #1 out_ready_ab = 1'b0;
        send_ab(32'hFFFF_FFFD); send_ab(32'hFFFF_FFFC); send_ab(32'd11); send_ab(32'd12);
        send_ab(32'hFFFF_FFFE); send_ab(32'hFFFF_FFF8);
        stop_ab();
        check_val("t6_pend_valid", 64'(out_valid_a), 64'd1);
        check_val("t6_pend_a", 64'(out_act_a), 64'hFFFF_FFFE);
        check_val("t6_pend_b", 64'(out_act_b), 64'hFFFF_FFFE);
        #1 rst_n = 1'b0;
        #1 check_val("t6_rst_valid_a", 64'(out_valid_a), 64'd0);
        check_val("t6_rst_valid_b", 64'(out_valid_b), 64'd0);
        check_val("t6_rst_act_a", 64'(out_act_a), 64'd0);
        #1 rst_n = 1'b1;
        out_ready_ab = 1'b1;
        @(posedge clk);
        expect_ab(32'd6, 32'd6);
        expect_ab(32'd8, 32'd8);
        send8('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
        stop_ab();

        // 3x2 pool, four channels of ramps, one beat per cycle with no stall.
        @(posedge clk);
        exp_c_q.push_back(64'h0000_0018_0064_0008);
        exp_c_q.push_back(64'hFFFD_0021_0061_000B);
        for (int i = 0; i < 12; i++) begin
            #1 in_valid_c = 1'b1;
            in_act_c = ramp_c(i);
            @(negedge clk);
            check_val("t3_in_ready", 64'(in_ready_c), 64'd1);
            check_val("t3_valid_timing", 64'(out_valid_c), (i == 9) ? 64'd1 : 64'd0);
            @(posedge clk);
        end
        #1 in_valid_c = 1'b0;
        @(negedge clk);
        check_val("t3_last_valid", 64'(out_valid_c), 64'd1);

        // Random stream with random valid gaps and random out_ready against a window model.
        for (int r = 0; r < NROWS; r++) begin
            for (int x = 0; x < 4; x++) begin
                rnd[r][x] = ($urandom_range(0, 2) == 0) ? 32'($urandom())
                                                        : 32'($urandom_range(0, 15)) - 32'd8;
            end
        end
        for (int r = 0; r < NROWS; r += 2) begin
            for (int p = 0; p < 2; p++) begin
                win[0] = rnd[r][2*p];   win[1] = rnd[r][2*p+1];
                win[2] = rnd[r+1][2*p]; win[3] = rnd[r+1][2*p+1];
                expect_ab(max4(win, 1'b1), max4(win, 1'b0));
            end
        end
        @(posedge clk);
        done = 1'b0;
        fork
            begin
                for (int r = 0; r < NROWS; r++) begin
                    for (int x = 0; x < 4; x++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            #1 in_valid_ab = 1'b0;
                            @(posedge clk);
                        end
                        send_ab(rnd[r][x]);
                    end
                end
                stop_ab();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    #1 out_ready_ab = 1'($urandom_range(0, 1));
                    @(posedge clk);
                end
            end
        join
        #1 out_ready_ab = 1'b1;
        wait_cyc = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        check_val("drain_a", 64'(exp_a_q.size()), 64'd0);
        check_val("drain_b", 64'(exp_b_q.size()), 64'd0);
        check_val("drain_c", 64'(exp_c_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
